// File: rtl/rpn_pkg.sv
// Shared types and per-opcode tables for the RPN command sequencer.
package rpn_pkg;

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_POP  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_DUP  = 3'd6,
        OP_SWAP = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP1,
        S_POP2,
        S_PUSHT,
        S_PUSHF,
        S_POPF,
        S_ERR
    } state_t;

    // Operands each opcode needs on the stack, and its net effect on occupancy.
    localparam logic [7:0] NEED [0:7] = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd2};
    localparam int         NET  [0:7] = '{1, -1, -1, -1, -1, -1, 1, 0};

endpackage

// File: rtl/rpn_alu.sv
// Combinational result generator: b is the entry under the top, a is the top.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res
);

    always_comb begin
        res = a;
        case (op_t'(op))
            OP_ADD:  res = b + a;
            OP_SUB:  res = b - a;
            OP_AND:  res = b & a;
            OP_OR:   res = b | a;
            OP_SWAP: res = b;
            default: res = a;
        endcase
    end

endmodule

// File: rtl/rpn_ctrl.sv
// RPN command sequencer: validates operand count against stack occupancy, then
// drives a fixed push/pop sequence into the LIFO stack for each accepted command.
module rpn_ctrl
    import rpn_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result,
    output logic         stk_push,
    output logic         stk_pop,
    output logic [W-1:0] stk_val,
    input  logic [W-1:0] stk_top,
    input  logic [W-1:0] stk_next,
    input  logic [7:0]   stk_count
);

    state_t       state, state_nx;
    op_t          op_in, op_q;
    logic [W-1:0] a, b, res, alu_res;
    logic         accept, reject;

    assign op_in     = op_t'(cmd_op);
    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign reject    = (stk_count < NEED[cmd_op]) ||
                       ((NET[cmd_op] > 0) && (stk_count == 8'(DEPTH)));

    rpn_alu #(.W(W)) u_alu (
        .op  (cmd_op),
        .a   (stk_top),
        .b   (stk_next),
        .res (alu_res)
    );

    // Operands and the final value are captured at accept so the sequence
    // is immune to the stack outputs moving while entries are popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= OP_PUSH;
            a      <= '0;
            b      <= '0;
            res    <= '0;
            result <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q <= op_in;
                a    <= stk_top;
                b    <= stk_next;
                case (op_in)
                    OP_PUSH: res <= cmd_data;
                    OP_POP:  res <= res;
                    default: res <= alu_res;
                endcase
            end
            if (state == S_PUSHF) begin
                result <= res;
            end
        end
    end

    always_comb begin
        state_nx = state;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_val  = '0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (reject) begin
                        state_nx = S_ERR;
                    end else begin
                        case (op_in)
                            OP_PUSH, OP_DUP: state_nx = S_PUSHF;
                            OP_POP:          state_nx = S_POPF;
                            default:         state_nx = S_POP1;
                        endcase
                    end
                end
            end
            S_POP1: begin
                stk_pop  = 1'b1;
                state_nx = S_POP2;
            end
            S_POP2: begin
                stk_pop  = 1'b1;
                state_nx = (op_q == OP_SWAP) ? S_PUSHT : S_PUSHF;
            end
            S_PUSHT: begin
                stk_push = 1'b1;
                stk_val  = a;
                state_nx = S_PUSHF;
            end
            S_PUSHF: begin
                // For SWAP the final value is the old next entry, which res also holds.
                stk_push = 1'b1;
                stk_val  = (op_q == OP_SWAP) ? b : res;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_POPF: begin
                stk_pop  = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_ERR: begin
                done     = 1'b1;
                err      = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rpn_ctrl.sv
// Bench for rpn_ctrl with a behavioural 32-entry stack attached.
module tb_rpn_ctrl;
    import rpn_pkg::*;

    typedef struct packed {
        logic       err;
        logic [7:0] lat;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        done;
    logic        err;
    logic [15:0] result;
    logic        stk_push;
    logic        stk_pop;
    logic [15:0] stk_val;
    logic [15:0] stk_top;
    logic [15:0] stk_next;
    logic [7:0]  stk_count;

    logic [15:0] smem [0:31];
    logic [7:0]  scount;
    logic [4:0]  tix, nix;

    resp_t       exp_q [$];
    resp_t       obs_q [$];
    logic [15:0] push_log [$];
    int          cyc, accept_cyc, push_cnt, pop_cnt, both_cnt;
    int          tests, fails;

    rpn_ctrl #(.DEPTH(32), .W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .done      (done),
        .err       (err),
        .result    (result),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_val   (stk_val),
        .stk_top   (stk_top),
        .stk_next  (stk_next),
        .stk_count (stk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack model sharing the controller's reset.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            scount <= 8'd0;
        end else if (stk_push && scount < 8'd32) begin
            smem[scount[4:0]] <= stk_val;
            scount <= scount + 8'd1;
        end else if (stk_pop && scount > 8'd0) begin
            scount <= scount - 8'd1;
        end
    end

    assign tix       = 5'(scount - 8'd1);
    assign nix       = 5'(scount - 8'd2);
    assign stk_top   = (scount > 8'd0) ? smem[tix] : 16'h0;
    assign stk_next  = (scount > 8'd1) ? smem[nix] : 16'h0;
    assign stk_count = scount;

    // Observe handshakes, stack actions and completions away from the clock edge.
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) accept_cyc = cyc;
        if (stk_push && stk_pop) both_cnt = both_cnt + 1;
        if (stk_push) begin
            push_cnt = push_cnt + 1;
            push_log.push_back(stk_val);
        end
        if (stk_pop) pop_cnt = pop_cnt + 1;
        if (done) obs_q.push_back('{err: err, lat: 8'(cyc - accept_cyc)});
    end

    task automatic doReset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        push_log.delete();
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] data,
                                 input logic e_err, input int e_lat);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        exp_q.push_back('{err: e_err, lat: 8'(e_lat)});
        n = obs_q.size();
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && obs_q.size() == n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        doReset();
        tests++;
        if ({cmd_ready, done, err, stk_push, stk_pop} !== 5'b10000) begin
            fails++;
            $display("[TB] FAIL reset_ctrl got %b want 10000", {cmd_ready, done, err, stk_push, stk_pop});
        end
        tests++;
        if ({stk_val, result} !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_data got %h want 00000000", {stk_val, result});
        end
    endtask

    task automatic test_add();
        resp_t e, o;
        doReset();
        applyStimulus(OP_PUSH, 16'h0005, 1'b0, 1);
        applyStimulus(OP_PUSH, 16'h0003, 1'b0, 1);
        applyStimulus(OP_ADD,  16'h0000, 1'b0, 3);
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("[TB] FAIL add_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL add_resp err/lat got %b/%0d want %b/%0d", o.err, o.lat, e.err, e.lat);
            end
        end
        tests++;
        if ({scount, stk_top, result} !== {8'd1, 16'h0008, 16'h0008}) begin
            fails++;
            $display("[TB] FAIL add_state cnt/top/result got %0d/%h/%h want 1/0008/0008", scount, stk_top, result);
        end
    endtask

    task automatic test_sub_reject();
        resp_t e, o;
        int pc, qc;
        doReset();
        applyStimulus(OP_PUSH, 16'h0002, 1'b0, 1);
        applyStimulus(OP_PUSH, 16'h0007, 1'b0, 1);
        applyStimulus(OP_SUB,  16'h0000, 1'b0, 3);
        tests++;
        if ({scount, stk_top} !== {8'd1, 16'hFFFB}) begin
            fails++;
            $display("[TB] FAIL sub_wrap cnt/top got %0d/%h want 1/fffb", scount, stk_top);
        end
        pc = push_cnt;
        qc = pop_cnt;
        applyStimulus(OP_SWAP, 16'h0000, 1'b1, 1);
        tests++;
        if (push_cnt != pc || pop_cnt != qc || scount != 8'd1) begin
            fails++;
            $display("[TB] FAIL swap_underflow push/pop/cnt got %0d/%0d/%0d want 0/0/1", push_cnt - pc, pop_cnt - qc, scount);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("[TB] FAIL sub_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL sub_resp err/lat got %b/%0d want %b/%0d", o.err, o.lat, e.err, e.lat);
            end
        end
    endtask

    task automatic test_logic_ops();
        resp_t e, o;
        doReset();
        applyStimulus(OP_PUSH, 16'hF0F0, 1'b0, 1);
        applyStimulus(OP_PUSH, 16'h0FF0, 1'b0, 1);
        applyStimulus(OP_AND,  16'h0000, 1'b0, 3);
        tests++;
        if (stk_top !== 16'h00F0) begin
            fails++;
            $display("[TB] FAIL and_top got %h want 00f0", stk_top);
        end
        applyStimulus(OP_PUSH, 16'h1200, 1'b0, 1);
        applyStimulus(OP_OR,   16'h0000, 1'b0, 3);
        tests++;
        if ({scount, stk_top, result} !== {8'd1, 16'h12F0, 16'h12F0}) begin
            fails++;
            $display("[TB] FAIL or_state cnt/top/result got %0d/%h/%h want 1/12f0/12f0", scount, stk_top, result);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("[TB] FAIL logic_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL logic_resp err/lat got %b/%0d want %b/%0d", o.err, o.lat, e.err, e.lat);
            end
        end
    endtask

    task automatic test_swap();
        resp_t e, o;
        int qc;
        doReset();
        applyStimulus(OP_PUSH, 16'h00AA, 1'b0, 1);
        applyStimulus(OP_PUSH, 16'h0055, 1'b0, 1);
        qc = pop_cnt;
        applyStimulus(OP_SWAP, 16'h0000, 1'b0, 4);
        tests++;
        if ({scount, stk_top, stk_next} !== {8'd2, 16'h00AA, 16'h0055}) begin
            fails++;
            $display("[TB] FAIL swap_state cnt/top/next got %0d/%h/%h want 2/00aa/0055", scount, stk_top, stk_next);
        end
        tests++;
        if (push_log.size() != 4 || pop_cnt - qc != 2) begin
            fails++;
            $display("[TB] FAIL swap_actions pushes/pops got %0d/%0d want 4/2", push_log.size(), pop_cnt - qc);
        end else if (push_log[2] !== 16'h0055 || push_log[3] !== 16'h00AA) begin
            fails++;
            $display("[TB] FAIL swap_order got %h,%h want 0055,00aa", push_log[2], push_log[3]);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("[TB] FAIL swap_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL swap_resp err/lat got %b/%0d want %b/%0d", o.err, o.lat, e.err, e.lat);
            end
        end
    endtask

    task automatic test_overflow();
        resp_t e, o;
        int pc;
        doReset();
        for (int i = 0; i < 32; i++) applyStimulus(OP_PUSH, 16'h0100 + 16'(i), 1'b0, 1);
        pc = push_cnt;
        applyStimulus(OP_PUSH, 16'hBEEF, 1'b1, 1);
        applyStimulus(OP_DUP,  16'h0000, 1'b1, 1);
        tests++;
        if ({scount, stk_top, result} !== {8'd32, 16'h011F, 16'h011F} || push_cnt != pc) begin
            fails++;
            $display("[TB] FAIL overflow cnt/top/result/pushes got %0d/%h/%h/%0d want 32/011f/011f/0", scount, stk_top, result, push_cnt - pc);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("[TB] FAIL overflow_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL overflow_resp err/lat got %b/%0d want %b/%0d", o.err, o.lat, e.err, e.lat);
            end
        end
    endtask

    task automatic test_underflow_dup();
        resp_t e, o;
        doReset();
        applyStimulus(OP_POP,  16'h0000, 1'b1, 1);
        tests++;
        if (scount !== 8'd0) begin
            fails++;
            $display("[TB] FAIL pop_empty cnt got %0d want 0", scount);
        end
        applyStimulus(OP_PUSH, 16'h1234, 1'b0, 1);
        applyStimulus(OP_DUP,  16'h0000, 1'b0, 1);
        tests++;
        if ({scount, stk_top, stk_next} !== {8'd2, 16'h1234, 16'h1234}) begin
            fails++;
            $display("[TB] FAIL dup_state cnt/top/next got %0d/%h/%h want 2/1234/1234", scount, stk_top, stk_next);
        end
        applyStimulus(OP_POP,  16'h0000, 1'b0, 1);
        tests++;
        if ({scount, stk_top} !== {8'd1, 16'h1234}) begin
            fails++;
            $display("[TB] FAIL pop_state cnt/top got %0d/%h want 1/1234", scount, stk_top);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("[TB] FAIL dup_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL dup_resp err/lat got %b/%0d want %b/%0d", o.err, o.lat, e.err, e.lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pc;
        doReset();
        applyStimulus(OP_PUSH, 16'h0001, 1'b0, 1);
        applyStimulus(OP_PUSH, 16'h0002, 1'b0, 1);
        exp_q.delete();
        obs_q.delete();
        pc = push_cnt;
        cmd_op    = OP_ADD;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (stk_pop !== 1'b1 || cmd_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_pop2 pop/ready got %b/%b want 1/0", stk_pop, cmd_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({cmd_ready, done, stk_push, stk_pop} !== 4'b1000 || scount !== 8'd0) begin
            fails++;
            $display("[TB] FAIL mid_reset rdy/done/push/pop got %b cnt %0d want 1000 cnt 0", {cmd_ready, done, stk_push, stk_pop}, scount);
        end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (push_cnt != pc || obs_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL mid_after pushes/dones got %0d/%0d want 0/0", push_cnt - pc, obs_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_data = 16'h0;
        cyc = 0;
        accept_cyc = 0;
        push_cnt = 0;
        pop_cnt = 0;
        both_cnt = 0;
        tests = 0;
        fails = 0;
        test_reset();
        test_add();
        test_sub_reject();
        test_logic_ops();
        test_swap();
        test_overflow();
        test_underflow_dup();
        test_reset_mid();
        tests++;
        if (both_cnt != 0) begin
            fails++;
            $display("[TB] FAIL push_and_pop got %0d cycles want 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rpn_ctrl.md
Name: rpn_ctrl

Overview:
- Command sequencer for the 16-bit LIFO stack (push/pop/val in; top/next/counter out).
- Accepts one RPN command at a time over a valid/ready handshake.
- Checks operand count against the stack occupancy, then issues a fixed sequence of single-cycle push/pop actions so the stack ends in the post-operation state.
- Sits between the command source (keypad/bus decoder) and the stack instance; owns the stack's push/pop/val inputs exclusively.

Parameters:
- DEPTH, 32, stack capacity in entries; must match the stack's 5-bit address space.
- W, 16, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command (IDLE only)
- cmd_op  in  3  opcode: 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 DUP, 7 SWAP
- cmd_data  in  W  immediate for PUSH; ignored otherwise
- done  out  1  one-cycle pulse when a command completes or is rejected
- err  out  1  valid with done; 1 means the command was rejected
- result  out  W  last value pushed by the controller
- stk_push  out  1  to stack push
- stk_pop  out  1  to stack pop
- stk_val  out  W  to stack val
- stk_top  in  W  from stack top
- stk_next  in  W  from stack next
- stk_count  in  8  from stack counter

Behaviour:
- Reset:
  - state is IDLE.
  - cmd_ready=1; done, err, stk_push and stk_pop are 0.
  - stk_val, result and the internal latches a, b, res are 0.
- Reset mid-sequence aborts the sequence with no further stack actions. The stack shares rst and clears too.
- Accept: cmd_valid && cmd_ready in cycle T. In that cycle, latch:
  - op
  - a <= stk_top
  - b <= stk_next
  - res, set per op:
    - PUSH: cmd_data
    - DUP: stk_top
    - ADD: b+a (16-bit wraparound, carry dropped)
    - SUB: b-a (borrow dropped)
    - AND: b&a
    - OR: b|a
    - SWAP: b
    - POP: unchanged
- Check at accept, using stk_count at T:
  - Underflow: count < need. need is 1 for POP/DUP, 2 for ADD/SUB/AND/OR/SWAP, 0 for PUSH.
  - Overflow: count == DEPTH for PUSH/DUP.
  - On a failed check go to ERR: T+1 has done=1, err=1, and no push or pop. The stack is untouched.
- States: IDLE, POP1, POP2, PUSHT, PUSHF, POPF, ERR. Each non-IDLE state lasts exactly 1 cycle.
  - PUSH/DUP: IDLE -> PUSHF.
  - POP: IDLE -> POPF.
  - ADD/SUB/AND/OR: IDLE -> POP1 -> POP2 -> PUSHF.
  - SWAP: IDLE -> POP1 -> POP2 -> PUSHT -> PUSHF.
  - POPF, PUSHF, ERR -> IDLE.
- Per-state outputs:
  - POP1/POP2/POPF: stk_pop=1.
  - PUSHT: stk_push=1, stk_val=a.
  - PUSHF: stk_push=1, stk_val=res, result<=res.
  - stk_val is 0 outside push states.
  - done=1 in PUSHF, POPF and ERR; err=1 only in ERR.
- stk_push and stk_pop are never both 1. At most one stack action per cycle.
- Latency from accept T to done:
  - PUSH/DUP/POP: T+1
  - ALU ops: T+3
  - SWAP: T+4
  - reject: T+1
- cmd_ready is 0 from T+1 through the done cycle and returns to 1 in the cycle after done.
- Latched operands are used throughout the sequence. Mid-sequence top/next changes have no effect.
- Stack occupancy is always in 0..DEPTH. The controller never causes a wrap of the stack counter.

Decomposition:
- Package rpn_pkg holds:
  - opcode enum op_t (3 bits)
  - state enum state_t
  - localparams NEED[op] and NET[op] (+1/-1/0)
- One combinational sub-module, rpn_alu (op, a, b -> res). All sequencing stays in rpn_ctrl.
- The bench instantiates rpn_ctrl together with the stack.

Test Plan:
- Reset then PUSH 5, PUSH 3, ADD -> done at T+3 with err=0; counter=1; top=0x0008; result=0x0008.
- PUSH 0x0002, PUSH 0x0007, SUB -> top=0xFFFB (wrap). Then SWAP with only 1 entry -> done with err=1 at T+1; counter stays 1; no stk_push/stk_pop pulse.
- PUSH 0x00AA, PUSH 0x0055, SWAP -> pop, pop, push 0x0055, push 0x00AA. Final top=0x00AA, next=0x0055, counter=2; done at T+4.
- Fill to 32 entries with PUSH; 33rd PUSH and a DUP -> err=1 each; counter stays 32; top unchanged.
- POP on empty stack -> err=1. Then PUSH 0x1234, DUP -> top=next=0x1234, counter=2.
- Assert rst during POP2 of an ADD -> next cycle state IDLE, cmd_ready=1, no push issued, counter=0.
